// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundles the scanned 7-segment bus observed by seg7_scan_decoder together
// with the reconstructed-value outputs it produces.
//   display     [6:0]  segment bus, active-low, bit0=a .. bit6=g
//   on_off      [3:0]  anode enables, active-low, on_off[i]=0 selects digit i
//   value       [15:0] last complete frame, value[4i+3:4i] = digit i
//   frame_done         one-cycle pulse when value is updated
//   frame_ok           last completed frame had four legal segment patterns
//   seg_error          one-cycle pulse on capture of an unrecognised pattern
//   anode_error        one-cycle pulse on a stable multi-digit anode pattern
// master: the side driving the display (driver model / testbench)
// slave : the decoder
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if;
    logic [6:0]  display;
    logic [3:0]  on_off;
    logic [15:0] value;
    logic        frame_done;
    logic        frame_ok;
    logic        seg_error;
    logic        anode_error;

    modport master (
        output display, on_off,
        input  value, frame_done, frame_ok, seg_error, anode_error
    );

    modport slave (
        input  display, on_off,
        output value, frame_done, frame_ok, seg_error, anode_error
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Watches a 4-digit multiplexed 7-segment display (segment bus + anode
// enables) and rebuilds the four displayed hex digits into one 16-bit value.
// A digit is captured once per anode dwell after the anode pattern has been
// stable long enough; once all four slots have been seen the frame is
// published atomically.
// Ports:
//   clk_in  : system clock, rising edge
//   reset   : asynchronous, active-high, clears all state
//   bus     : seg7_scan_decoder_if.slave (display/on_off in, results out)
// Parameters:
//   SETTLE_CYCLES : stable cycles required before capture (1..255)
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk_in,
    input  logic                 reset,
    seg7_scan_decoder_if.slave   bus
);

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_CAP = 8'(SETTLE_CYCLES - 1);

    // Active-high {g..a} pattern to {valid, nibble}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   seg_decode = {1'b1, 4'h0};
            7'h06:   seg_decode = {1'b1, 4'h1};
            7'h5B:   seg_decode = {1'b1, 4'h2};
            7'h4F:   seg_decode = {1'b1, 4'h3};
            7'h66:   seg_decode = {1'b1, 4'h4};
            7'h6D:   seg_decode = {1'b1, 4'h5};
            7'h7D:   seg_decode = {1'b1, 4'h6};
            7'h07:   seg_decode = {1'b1, 4'h7};
            7'h7F:   seg_decode = {1'b1, 4'h8};
            7'h6F:   seg_decode = {1'b1, 4'h9};
            7'h77:   seg_decode = {1'b1, 4'hA};
            7'h7C:   seg_decode = {1'b1, 4'hB};
            7'h39:   seg_decode = {1'b1, 4'hC};
            7'h5E:   seg_decode = {1'b1, 4'hD};
            7'h79:   seg_decode = {1'b1, 4'hE};
            7'h71:   seg_decode = {1'b1, 4'hF};
            default: seg_decode = {1'b0, 4'h0};
        endcase
    endfunction

    // Active-high anode mask to {legal one-hot, slot index}.
    function automatic logic [2:0] slot_of(input logic [3:0] an);
        case (an)
            4'b0001: slot_of = {1'b1, 2'd0};
            4'b0010: slot_of = {1'b1, 2'd1};
            4'b0100: slot_of = {1'b1, 2'd2};
            4'b1000: slot_of = {1'b1, 2'd3};
            default: slot_of = {1'b0, 2'd0};
        endcase
    endfunction

    logic [6:0]  d_q, d_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  a_prev_q, a_prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  seen_q, seen_d;
    logic        bad_q, bad_d;
    logic [15:0] value_q, value_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_ok_q, frame_ok_d;
    logic        seg_error_q, seg_error_d;
    logic        anode_error_q, anode_error_d;

    logic [4:0]  dec_s;
    logic [2:0]  slot_s;
    logic        changed_s;
    logic        capture_s;
    logic        complete_s;

    assign dec_s      = seg_decode(~d_q);
    assign slot_s     = slot_of(~a_q);
    assign changed_s  = (a_q != a_prev_q);
    // Counter only passes SETTLE_CAP once per dwell, so one capture per dwell.
    assign capture_s  = !changed_s && (cnt_q == SETTLE_CAP);
    assign complete_s = (seen_q == 4'hF);

    // Next-state logic: input stage, settle counter, capture and frame publish.
    always_comb begin
        d_d           = bus.display;
        a_d           = bus.on_off;
        a_prev_d      = a_q;
        shadow_d      = shadow_q;
        seen_d        = seen_q;
        bad_d         = bad_q;
        value_d       = value_q;
        frame_done_d  = 1'b0;
        frame_ok_d    = frame_ok_q;
        seg_error_d   = 1'b0;
        anode_error_d = 1'b0;

        if (changed_s) begin
            cnt_d = 8'd0;
        end else if (cnt_q < SETTLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // Publish one cycle after the fourth slot was seen; the partial-frame
        // tracking restarts in the same cycle.
        if (complete_s) begin
            value_d      = shadow_q;
            frame_ok_d   = !bad_q;
            frame_done_d = 1'b1;
            seen_d       = 4'h0;
            bad_d        = 1'b0;
        end else begin
            frame_done_d = 1'b0;
        end

        if (capture_s) begin
            if (slot_s[2]) begin
                shadow_d[{slot_s[1:0], 2'b00} +: 4] = dec_s[3:0];
                seen_d[slot_s[1:0]] = 1'b1;
                if (!dec_s[4]) begin
                    seg_error_d = 1'b1;
                    bad_d       = 1'b1;
                end else begin
                    seg_error_d = 1'b0;
                end
            end else if (a_q != 4'hF) begin
                // Two or more anodes driven at once.
                anode_error_d = 1'b1;
            end else begin
                // Blanking interval: nothing to capture.
                anode_error_d = 1'b0;
            end
        end else begin
            seg_error_d = 1'b0;
        end
    end

    // State registers; reset leaves the input stage showing "all off".
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            d_q           <= 7'h7F;
            a_q           <= 4'hF;
            a_prev_q      <= 4'hF;
            cnt_q         <= 8'd0;
            shadow_q      <= 16'h0000;
            seen_q        <= 4'h0;
            bad_q         <= 1'b0;
            value_q       <= 16'h0000;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            seg_error_q   <= 1'b0;
            anode_error_q <= 1'b0;
        end else begin
            d_q           <= d_d;
            a_q           <= a_d;
            a_prev_q      <= a_prev_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            seen_q        <= seen_d;
            bad_q         <= bad_d;
            value_q       <= value_d;
            frame_done_q  <= frame_done_d;
            frame_ok_q    <= frame_ok_d;
            seg_error_q   <= seg_error_d;
            anode_error_q <= anode_error_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_ok    = frame_ok_q;
    assign bus.seg_error   = seg_error_q;
    assign bus.anode_error = anode_error_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed, table-driven bench for seg7_scan_decoder (SETTLE_CYCLES = 4).
// A table of whole frames is scanned in slot order and checked; hand-written
// sequences cover short dwell, anode faults, reset mid-frame and
// out-of-order / duplicate scanning.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(.SETTLE_CYCLES(4)) dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_done   = 0;
    int n_seg    = 0;
    int n_anode  = 0;
    int last_done_cyc = 0;

    // Cycle counter.
    always @(posedge clk) cyc++;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) begin
            n_done++;
            last_done_cyc = cyc;
        end
        if (bus.seg_error === 1'b1) n_seg++;
        if (bus.anode_error === 1'b1) n_anode++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Active-low pattern for a hex digit, from the segment table.
    function automatic logic [6:0] seg_al(input logic [3:0] n);
        logic [6:0] hi;
        case (n)
            4'h0: hi = 7'h3F;  4'h1: hi = 7'h06;  4'h2: hi = 7'h5B;  4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66;  4'h5: hi = 7'h6D;  4'h6: hi = 7'h7D;  4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F;  4'h9: hi = 7'h6F;  4'hA: hi = 7'h77;  4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39;  4'hD: hi = 7'h5E;  4'hE: hi = 7'h79;  default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    function automatic logic [3:0] slot_an(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

    // Drive a pattern (called #1 after a rising edge) and hold it n cycles.
    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.on_off  = an;
        bus.display = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        dwell(4'hF, 7'h7F, n);
    endtask

    typedef struct {
        logic [3:0][6:0] disp;
        logic [15:0]     exp_value;
        logic            exp_ok;
        int              exp_seg;
    } frame_t;

    frame_t frames[5];

    initial begin
        int d0, s0, a0, c0;

        frames[0] = '{disp: {7'h19, 7'h30, 7'h24, 7'h79}, exp_value: 16'h4321, exp_ok: 1'b1, exp_seg: 1'b0};
        frames[1] = '{disp: {seg_al(4'h4), 7'h7F, seg_al(4'h2), seg_al(4'h1)}, exp_value: 16'h4021, exp_ok: 1'b0, exp_seg: 1};
        frames[2] = '{disp: {seg_al(4'hD), seg_al(4'hC), seg_al(4'hB), seg_al(4'hA)}, exp_value: 16'hDCBA, exp_ok: 1'b1, exp_seg: 0};
        frames[3] = '{disp: {7'h7E, seg_al(4'h7), seg_al(4'h6), seg_al(4'h5)}, exp_value: 16'h0765, exp_ok: 1'b0, exp_seg: 1};
        frames[4] = '{disp: {seg_al(4'h8), seg_al(4'h0), seg_al(4'hF), seg_al(4'hE)}, exp_value: 16'h80FE, exp_ok: 1'b1, exp_seg: 0};

        bus.on_off  = 4'hF;
        bus.display = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check("reset_value", 32'(bus.value), 32'h0);
        check("reset_frame_ok", 32'(bus.frame_ok), 32'h0);
        check("reset_frame_done", 32'(bus.frame_done), 32'h0);
        rst = 1'b0;
        blank(3);

        // Table-driven whole frames, slots scanned 0..3.
        for (int f = 0; f < 5; f++) begin
            d0 = n_done; s0 = n_seg; a0 = n_anode;
            for (int i = 0; i < 4; i++) dwell(slot_an(i), frames[f].disp[i], 10);
            blank(3);
            check($sformatf("frame%0d_done_count", f), 32'(n_done - d0), 32'd1);
            check($sformatf("frame%0d_value", f), 32'(bus.value), 32'(frames[f].exp_value));
            check($sformatf("frame%0d_ok", f), 32'(bus.frame_ok), 32'(frames[f].exp_ok));
            check($sformatf("frame%0d_seg_err", f), 32'(n_seg - s0), 32'(frames[f].exp_seg));
            check($sformatf("frame%0d_anode_err", f), 32'(n_anode - a0), 32'd0);
        end

        // Short dwell on slot 3, then a minimum-length dwell completes.
        d0 = n_done;
        dwell(slot_an(0), seg_al(4'h1), 10);
        dwell(slot_an(1), seg_al(4'h2), 10);
        dwell(slot_an(2), seg_al(4'h3), 10);
        dwell(slot_an(3), seg_al(4'h4), 3);
        blank(10);
        check("short_dwell_no_frame", 32'(n_done - d0), 32'd0);
        c0 = cyc;
        dwell(slot_an(3), seg_al(4'h4), 5);
        blank(5);
        check("min_dwell_frame", 32'(n_done - d0), 32'd1);
        check("frame_done_latency", 32'(last_done_cyc - c0), 32'd7);
        check("min_dwell_value", 32'(bus.value), 32'h4321);

        // Anode fault mid-frame: one error, seen mask untouched.
        d0 = n_done; a0 = n_anode;
        dwell(slot_an(0), seg_al(4'h7), 10);
        dwell(slot_an(1), seg_al(4'h3), 10);
        dwell(4'b1100, seg_al(4'h8), 8);
        check("anode_err_pulse", 32'(n_anode - a0), 32'd1);
        check("anode_err_no_frame", 32'(n_done - d0), 32'd0);
        blank(10);
        check("blank_no_anode_err", 32'(n_anode - a0), 32'd1);
        dwell(slot_an(2), seg_al(4'h9), 10);
        dwell(slot_an(3), seg_al(4'h2), 10);
        blank(3);
        check("anode_fault_frame", 32'(n_done - d0), 32'd1);
        check("anode_fault_value", 32'(bus.value), 32'h2937);
        check("anode_fault_ok", 32'(bus.frame_ok), 32'h1);

        // Reset mid-frame discards partial state.
        dwell(slot_an(0), seg_al(4'hF), 10);
        dwell(slot_an(1), seg_al(4'hF), 10);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", 32'(bus.value), 32'h0);
        check("rst_frame_ok", 32'(bus.frame_ok), 32'h0);
        check("rst_frame_done", 32'(bus.frame_done), 32'h0);
        check("rst_seg_error", 32'(bus.seg_error), 32'h0);
        check("rst_anode_error", 32'(bus.anode_error), 32'h0);
        rst = 1'b0;
        d0 = n_done;
        dwell(slot_an(1), seg_al(4'h8), 10);
        dwell(slot_an(2), seg_al(4'h7), 10);
        dwell(slot_an(3), seg_al(4'h6), 10);
        blank(3);
        check("rst_partial_discarded", 32'(n_done - d0), 32'd0);
        dwell(slot_an(0), seg_al(4'h9), 10);
        blank(3);
        check("rst_frame_done_count", 32'(n_done - d0), 32'd1);
        check("rst_frame_value", 32'(bus.value), 32'h6789);
        check("rst_frame_ok_after", 32'(bus.frame_ok), 32'h1);

        // Out-of-order scan with slot 0 re-captured.
        d0 = n_done;
        dwell(4'b0111, seg_al(4'hF), 10); blank(2);
        dwell(4'b1110, seg_al(4'h0), 10); blank(2);
        dwell(4'b1110, seg_al(4'h5), 10); blank(2);
        dwell(4'b1011, seg_al(4'hA), 10); blank(2);
        check("ooo_no_early_frame", 32'(n_done - d0), 32'd0);
        dwell(4'b1101, seg_al(4'hC), 10); blank(3);
        check("ooo_done_count", 32'(n_done - d0), 32'd1);
        check("ooo_value", 32'(bus.value), 32'hFAC5);
        check("ooo_ok", 32'(bus.frame_ok), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
